// File: rtl/spi_peripheral_ht16d35a_rx.sv
// Receive-only 3-wire SPI target modelling the HT16D35A input side.
// Ports: clk/reset (sync, active high); sck/dio/cs pins (async);
//   rx_data/rx_first/rx_valid/rx_ready head-of-FIFO stream;
//   busy, txn_done, txn_bytes transaction status; err_partial,
//   err_gap, err_overflow sticky protocol errors (cleared on cs fall).
module spi_peripheral_ht16d35a_rx #(
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_2us    = 100,
    parameter int GAP_SZ     = $clog2(CLK_2us + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sck,
    input  logic       dio,
    input  logic       cs,
    output logic [7:0] rx_data,
    output logic       rx_first,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       txn_done,
    output logic [7:0] txn_bytes,
    output logic       err_partial,
    output logic       err_gap,
    output logic       err_overflow
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [GAP_SZ-1:0] GAP_MAX = GAP_SZ'(CLK_2us);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    state_t state, state_nxt;

    logic sck_s1, sck_s2, sck_s3;
    logic cs_s1, cs_s2, cs_s3;
    logic dio_s1, dio_s2;
    logic [1:0] fill;
    logic cs_armed;

    logic [2:0] bit_cnt;
    logic [6:0] shift;
    logic first_flag;
    logic [GAP_SZ-1:0] gap_cnt;

    logic [8:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] cnt;

    logic cs_fall, cs_rise, sck_rise, sck_fall;
    logic qual, q_rise, q_fall, byte_done;
    logic full, pop, push;
    logic [7:0] byte_val;

    // Synchronizers, preset to the idle pin levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_s1 <= 1'b1;
            sck_s2 <= 1'b1;
            sck_s3 <= 1'b1;
            cs_s1  <= 1'b1;
            cs_s2  <= 1'b1;
            cs_s3  <= 1'b1;
            dio_s1 <= 1'b0;
            dio_s2 <= 1'b0;
            fill   <= 2'b00;
            cs_armed <= 1'b0;
        end else begin
            sck_s1 <= sck;
            sck_s2 <= sck_s1;
            sck_s3 <= sck_s2;
            cs_s1  <= cs;
            cs_s2  <= cs_s1;
            cs_s3  <= cs_s2;
            dio_s1 <= dio;
            dio_s2 <= dio_s1;
            fill   <= {fill[0], 1'b1};
            // A cs fall only counts once cs has genuinely been seen high
            // after reset; the preset levels alone do not arm it.
            cs_armed <= cs_armed | (fill[1] & cs_s2);
        end
    end

    assign cs_fall  = cs_armed & ~cs_s2 & cs_s3;
    assign cs_rise  = cs_s2 & ~cs_s3;
    assign sck_rise = sck_s2 & ~sck_s3;
    assign sck_fall = ~sck_s2 & sck_s3;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (cs_fall) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (cs_rise) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_ACTIVE);

    // cs high in the same cycle disqualifies the edge, which also
    // covers an sck edge coincident with the cs deassert edge.
    assign qual      = busy & ~cs_s2;
    assign q_rise    = qual & sck_rise;
    assign q_fall    = qual & sck_fall;
    assign byte_done = q_rise & (bit_cnt == 3'd7);
    assign byte_val  = {shift, dio_s2};

    assign rx_valid = (cnt != '0);
    assign full     = (cnt == DEPTH_C);
    assign pop      = rx_valid & rx_ready;
    assign push     = byte_done & (~full | pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt      <= 3'd0;
            shift        <= 7'd0;
            first_flag   <= 1'b0;
            gap_cnt      <= '0;
            txn_bytes    <= 8'd0;
            txn_done     <= 1'b0;
            err_partial  <= 1'b0;
            err_gap      <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            txn_done <= cs_rise;
            if (cs_fall) begin
                bit_cnt      <= 3'd0;
                txn_bytes    <= 8'd0;
                err_partial  <= 1'b0;
                err_gap      <= 1'b0;
                err_overflow <= 1'b0;
                first_flag   <= 1'b1;
                // Preload so the first byte is never gap-checked.
                gap_cnt      <= GAP_MAX;
            end else begin
                if (byte_done)
                    gap_cnt <= '0;
                else if (sck_s2 && gap_cnt < GAP_MAX)
                    gap_cnt <= gap_cnt + 1'b1;

                if (q_fall && bit_cnt == 3'd0 && gap_cnt < GAP_MAX)
                    err_gap <= 1'b1;

                if (q_rise) begin
                    shift   <= {shift[5:0], dio_s2};
                    bit_cnt <= bit_cnt + 3'd1;
                end

                if (push) begin
                    first_flag <= 1'b0;
                    if (txn_bytes != 8'hFF)
                        txn_bytes <= txn_bytes + 8'd1;
                end

                if (byte_done && !push)
                    err_overflow <= 1'b1;

                if (cs_rise && bit_cnt != 3'd0) begin
                    err_partial <= 1'b1;
                    bit_cnt     <= 3'd0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {first_flag, byte_val};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Head is forced to zero when empty so no stale entry is shown.
    assign rx_data  = rx_valid ? mem[rd_ptr][7:0] : 8'd0;
    assign rx_first = rx_valid ? mem[rd_ptr][8]   : 1'b0;

endmodule

// File: tb/tb_spi_peripheral_ht16d35a_rx.sv
// Directed testbench for spi_peripheral_ht16d35a_rx.
// Drives SPI pins at 8 clk per half-bit and checks the output stream.
module tb_spi_peripheral_ht16d35a_rx;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       sck;
    logic       dio;
    logic       cs;
    logic [7:0] rx_data;
    logic       rx_first;
    logic       rx_valid;
    logic       rx_ready;
    logic       busy;
    logic       txn_done;
    logic [7:0] txn_bytes;
    logic       err_partial;
    logic       err_gap;
    logic       err_overflow;

    int passed = 0;
    int total  = 0;
    int done_cnt = 0;
    logic [8:0] got [$];

    spi_peripheral_ht16d35a_rx #(
        .FIFO_DEPTH(4),
        .CLK_2us(100)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sck(sck),
        .dio(dio),
        .cs(cs),
        .rx_data(rx_data),
        .rx_first(rx_first),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .busy(busy),
        .txn_done(txn_done),
        .txn_bytes(txn_bytes),
        .err_partial(err_partial),
        .err_gap(err_gap),
        .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid === 1'b1 && rx_ready === 1'b1)
            got.push_back({rx_first, rx_data});
        if (txn_done === 1'b1)
            done_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] v, input int n,
                             input int hi_after);
        for (int i = 7; i > 7 - n; i--) begin
            sck = 1'b0;
            dio = v[i];
            tick(HALF);
            sck = 1'b1;
            tick((i == 8 - n) ? hi_after : HALF);
        end
    endtask

    task automatic cs_begin();
        cs = 1'b0;
        tick(8);
    endtask

    task automatic cs_end();
        cs = 1'b1;
        tick(10);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        total++; if (rx_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", rx_valid); else passed++;
        total++; if (rx_data !== 8'h00) $display("FAIL rst_data got=%h exp=00", rx_data); else passed++;
        total++; if (rx_first !== 1'b0) $display("FAIL rst_first got=%b exp=0", rx_first); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else passed++;
        total++; if (txn_done !== 1'b0) $display("FAIL rst_done got=%b exp=0", txn_done); else passed++;
        total++; if (txn_bytes !== 8'd0) $display("FAIL rst_bytes got=%0d exp=0", txn_bytes); else passed++;
        total++; if ({err_partial, err_gap, err_overflow} !== 3'b000)
            $display("FAIL rst_err got=%b exp=000", {err_partial, err_gap, err_overflow}); else passed++;
        reset = 1'b0;
        tick(6);
    endtask

    task automatic test_single();
        got.delete();
        done_cnt = 0;
        rx_ready = 1'b1;
        cs_begin();
        total++; if (busy !== 1'b1) $display("FAIL single_busy got=%b exp=1", busy); else passed++;
        send_bits(8'hA5, 8, 120);
        cs_end();
        total++; if (got.size() !== 1) $display("FAIL single_count got=%0d exp=1", got.size()); else passed++;
        if (got.size() > 0) begin
            total++; if (got[0] !== 9'h1A5) $display("FAIL single_entry got=%h exp=1a5", got[0]); else passed++;
        end
        total++; if (done_cnt !== 1) $display("FAIL single_done got=%0d exp=1", done_cnt); else passed++;
        total++; if (txn_bytes !== 8'd1) $display("FAIL single_bytes got=%0d exp=1", txn_bytes); else passed++;
        total++; if ({err_partial, err_gap, err_overflow} !== 3'b000)
            $display("FAIL single_err got=%b exp=000", {err_partial, err_gap, err_overflow}); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL single_idle got=%b exp=0", busy); else passed++;
    endtask

    task automatic test_three();
        logic [8:0] exp [3];
        exp[0] = 9'h180;
        exp[1] = 9'h001;
        exp[2] = 9'h0FF;
        got.delete();
        rx_ready = 1'b1;
        cs_begin();
        send_bits(8'h80, 8, 120);
        send_bits(8'h01, 8, 120);
        send_bits(8'hFF, 8, 120);
        cs_end();
        total++; if (got.size() !== 3) $display("FAIL three_count got=%0d exp=3", got.size()); else passed++;
        for (int k = 0; k < 3; k++) begin
            if (k < got.size()) begin
                total++; if (got[k] !== exp[k]) $display("FAIL three_entry%0d got=%h exp=%h", k, got[k], exp[k]); else passed++;
            end
        end
        total++; if (txn_bytes !== 8'd3) $display("FAIL three_bytes got=%0d exp=3", txn_bytes); else passed++;
        total++; if (err_gap !== 1'b0) $display("FAIL three_gap got=%b exp=0", err_gap); else passed++;
    endtask

    task automatic test_gap();
        got.delete();
        rx_ready = 1'b1;
        cs_begin();
        send_bits(8'h11, 8, 60);
        send_bits(8'h22, 8, 120);
        cs_end();
        total++; if (got.size() !== 2) $display("FAIL gap_count got=%0d exp=2", got.size()); else passed++;
        if (got.size() == 2) begin
            total++; if (got[1] !== 9'h022) $display("FAIL gap_entry got=%h exp=022", got[1]); else passed++;
        end
        total++; if (err_gap !== 1'b1) $display("FAIL gap_flag got=%b exp=1", err_gap); else passed++;
        cs_begin();
        total++; if (err_gap !== 1'b0) $display("FAIL gap_clear got=%b exp=0", err_gap); else passed++;
        cs_end();
    endtask

    task automatic test_partial();
        got.delete();
        rx_ready = 1'b1;
        cs_begin();
        send_bits(8'h3C, 8, 120);
        send_bits(8'hE8, 5, HALF);
        cs_end();
        total++; if (got.size() !== 1) $display("FAIL part_count got=%0d exp=1", got.size()); else passed++;
        if (got.size() > 0) begin
            total++; if (got[0] !== 9'h13C) $display("FAIL part_entry got=%h exp=13c", got[0]); else passed++;
        end
        total++; if (txn_bytes !== 8'd1) $display("FAIL part_bytes got=%0d exp=1", txn_bytes); else passed++;
        total++; if (err_partial !== 1'b1) $display("FAIL part_flag got=%b exp=1", err_partial); else passed++;
    endtask

    task automatic test_overflow();
        logic [8:0] exp [4];
        exp[0] = 9'h110;
        exp[1] = 9'h011;
        exp[2] = 9'h012;
        exp[3] = 9'h013;
        got.delete();
        rx_ready = 1'b0;
        cs_begin();
        for (int b = 0; b < 6; b++)
            send_bits(8'h10 + 8'(b), 8, 120);
        cs_end();
        total++; if (err_overflow !== 1'b1) $display("FAIL ovf_flag got=%b exp=1", err_overflow); else passed++;
        total++; if (txn_bytes !== 8'd4) $display("FAIL ovf_bytes got=%0d exp=4", txn_bytes); else passed++;
        total++; if ({rx_valid, rx_first, rx_data} !== 10'h310)
            $display("FAIL ovf_head got=%h exp=310", {rx_valid, rx_first, rx_data}); else passed++;
        total++; if (err_partial !== 1'b0) $display("FAIL ovf_partial got=%b exp=0", err_partial); else passed++;
        rx_ready = 1'b1;
        tick(8);
        rx_ready = 1'b0;
        total++; if (got.size() !== 4) $display("FAIL ovf_count got=%0d exp=4", got.size()); else passed++;
        for (int k = 0; k < 4; k++) begin
            if (k < got.size()) begin
                total++; if (got[k] !== exp[k]) $display("FAIL ovf_entry%0d got=%h exp=%h", k, got[k], exp[k]); else passed++;
            end
        end
        total++; if (rx_valid !== 1'b0) $display("FAIL ovf_drained got=%b exp=0", rx_valid); else passed++;
    endtask

    task automatic test_reset_mid();
        got.delete();
        rx_ready = 1'b1;
        cs_begin();
        send_bits(8'hF0, 4, HALF);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
        total++; if (busy !== 1'b0) $display("FAIL rmid_busy got=%b exp=0", busy); else passed++;
        total++; if (txn_bytes !== 8'd0) $display("FAIL rmid_bytes got=%0d exp=0", txn_bytes); else passed++;
        total++; if (rx_valid !== 1'b0) $display("FAIL rmid_valid got=%b exp=0", rx_valid); else passed++;
        send_bits(8'hA0, 4, HALF);
        send_bits(8'h77, 8, 120);
        total++; if (got.size() !== 0) $display("FAIL rmid_ignored got=%0d exp=0", got.size()); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rmid_nobusy got=%b exp=0", busy); else passed++;
        cs_end();
        cs_begin();
        send_bits(8'h5A, 8, 120);
        cs_end();
        total++; if (got.size() !== 1) $display("FAIL rmid_count got=%0d exp=1", got.size()); else passed++;
        if (got.size() > 0) begin
            total++; if (got[0] !== 9'h15A) $display("FAIL rmid_entry got=%h exp=15a", got[0]); else passed++;
        end
        total++; if ({err_partial, err_gap, err_overflow} !== 3'b000)
            $display("FAIL rmid_err got=%b exp=000", {err_partial, err_gap, err_overflow}); else passed++;
    endtask

    initial begin
        reset    = 1'b1;
        sck      = 1'b1;
        dio      = 1'b0;
        cs       = 1'b1;
        rx_ready = 1'b0;
        test_reset();
        test_single();
        test_three();
        test_gap();
        test_partial();
        test_overflow();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
